// File: rtl/vmux_sched_if.sv
// Command, select and flow-control bundle for the lane-permutation sequencer.
//   master : command source / datapath wrapper (drives commands, up_valid, dn_ready)
//   slave  : vmux_sched (drives cmd_ready, sel, up_ready, dn_valid, busy, done, err)
// Signals:
//   cmd_valid/cmd_ready   command handshake
//   cmd_op, cmd_k         permutation opcode and its bit index / rotate amount
//   cmd_len               beats to pass under the command's permutation
//   sel[N]                registered per-lane select codes to the mux array
//   up_valid/up_ready     upstream amplitude handshake
//   dn_valid/dn_ready     downstream (mux output) handshake
//   busy, done, err       status
interface vmux_sched_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned SEL_W = $clog2(N),
  parameter int unsigned LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [SEL_W-1:0] cmd_k;
  logic [LEN_W-1:0] cmd_len;
  logic [SEL_W-1:0] sel [N-1:0];
  logic             up_valid;
  logic             up_ready;
  logic             dn_valid;
  logic             dn_ready;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_k, cmd_len, up_valid, dn_ready,
    input  cmd_ready, sel, up_ready, dn_valid, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_k, cmd_len, up_valid, dn_ready,
    output cmd_ready, sel, up_ready, dn_valid, busy, done, err
  );
endinterface

// File: rtl/vmux_sched.sv
// Sequencer for the lane-permutation mux array of the QFT state-vector datapath.
// Accepts one permutation command (identity, pair swap, rotate, bit-reverse), latches the
// N lane select codes, then passes cmd_len amplitude beats with valid/ready pass-through.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    vmux_sched_if.slave: command handshake, sel codes, up/dn handshakes, status
module vmux_sched #(
  parameter int unsigned N     = 8,
  parameter int unsigned SEL_W = $clog2(N),
  parameter int unsigned LEN_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  vmux_sched_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [SEL_W-1:0] sel_q [N-1:0];
  logic [SEL_W-1:0] sel_d [N-1:0];

  // Select codes the offered command would produce, plus its illegal-index flag.
  logic [SEL_W-1:0] cmd_sel [N-1:0];
  logic             cmd_bad;

  function automatic logic [SEL_W-1:0] bit_rev(input logic [SEL_W-1:0] v);
    logic [SEL_W-1:0] r;
    for (int unsigned b = 0; b < SEL_W; b++) begin
      r[b] = v[SEL_W-1-b];
    end
    return r;
  endfunction

  always_comb begin
    cmd_bad = (bus.cmd_op == 2'd1) && (32'(bus.cmd_k) >= SEL_W);
    for (int unsigned i = 0; i < N; i++) begin
      unique case (bus.cmd_op)
        2'd0: cmd_sel[i] = SEL_W'(i);
        // An out-of-range bit index falls back to identity rather than a partial swap.
        2'd1: cmd_sel[i] = cmd_bad ? SEL_W'(i) : (SEL_W'(i) ^ (SEL_W'(1) << bus.cmd_k));
        // SEL_W-bit addition wraps naturally, giving mod N for power-of-2 N.
        2'd2: cmd_sel[i] = SEL_W'(i) + bus.cmd_k;
        2'd3: cmd_sel[i] = bit_rev(SEL_W'(i));
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    sel_d         = sel_q;
    bus.cmd_ready = 1'b0;
    bus.up_ready  = 1'b0;
    bus.dn_valid  = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = 1'b1;

    unique case (state_q)
      StIdle: begin
        bus.busy      = 1'b0;
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          sel_d   = cmd_sel;
          cnt_d   = bus.cmd_len;
          err_d   = cmd_bad;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Settling cycle for the mux array after sel changed.
        state_d = (cnt_q == '0) ? StDone : StRun;
      end
      StRun: begin
        bus.dn_valid = bus.up_valid;
        bus.up_ready = bus.dn_ready;
        if (bus.up_valid && bus.dn_ready) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        bus.done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        sel_q[i] <= SEL_W'(i);
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.sel = sel_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_vmux_sched.sv
// Self-checking bench for vmux_sched: directed scenarios plus randomized commands with
// randomized up_valid/dn_ready, checked against a behavioural model of the permutations
// and beat timing.
module tb_vmux_sched;
  localparam int unsigned N     = 8;
  localparam int unsigned SEL_W = $clog2(N);
  localparam int unsigned LEN_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  vmux_sched_if #(.N(N), .SEL_W(SEL_W), .LEN_W(LEN_W)) bus ();

  vmux_sched #(.N(N), .SEL_W(SEL_W), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc_wait;
    int first_dn;
    int done_c;
    int done_cnt;
    int beats;
    int hs_bad;
    int sel_moved;
    int err;
    int idle_after;
    int m_done_c;
  } res_t;

  // Lane i's source under each permutation, from plain arithmetic.
  function automatic int exp_sel(input int op, input int k, input int i);
    int r;
    int v;
    case (op)
      1: begin
        if (k >= int'(SEL_W)) return i;
        return ((i / (1 << k)) % 2 == 1) ? i - (1 << k) : i + (1 << k);
      end
      2: return (i + k) % int'(N);
      3: begin
        r = 0;
        v = i;
        for (int b = 0; b < int'(SEL_W); b++) begin
          r = r * 2 + v % 2;
          v = v / 2;
        end
        return r;
      end
      default: return i;
    endcase
  endfunction

  function automatic int sel_diff(input int op, input int k);
    int d = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (bus.sel[i] !== SEL_W'(exp_sel(op, k, i))) d++;
    end
    return d;
  endfunction

  // Issues one command and runs it to completion. Cycle c=0 is the cycle after acceptance.
  // mode 0: always ready; 1: dn_ready toggles 1,0,1.. from c=1; 2: random up/dn.
  task automatic do_cmd(input int op, input int k, input int len, input int mode,
                        output res_t r);
    logic [SEL_W-1:0] snap [N-1:0];
    int  left;
    int  limit;
    bit  uv, dr, running, acc;
    r = '{acc_wait: 0, first_dn: -1, done_c: -1, done_cnt: 0, beats: 0, hs_bad: 0,
          sel_moved: 0, err: -1, idle_after: 0, m_done_c: -1};
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.cmd_k     = SEL_W'(k);
    bus.cmd_len   = LEN_W'(len);
    acc = 1'b0;
    while (!acc && r.acc_wait < 20) begin
      #1;
      acc = (bus.cmd_ready === 1'b1);
      @(posedge clk);
      #1;
      r.acc_wait++;
    end
    bus.cmd_valid = 1'b0;
    if (!acc) return;
    left  = len;
    limit = len * 8 + 20;
    if (len == 0) r.m_done_c = 1;
    for (int c = 0; c <= limit; c++) begin
      running = (c >= 1) && (left > 0);
      if (mode == 0) begin
        uv = 1'b1;
        dr = 1'b1;
      end else if (mode == 1) begin
        uv = 1'b1;
        dr = (c >= 1) ? ((c - 1) % 2 == 0) : 1'b1;
      end else begin
        uv = ($urandom_range(3) != 0);
        dr = ($urandom_range(3) != 0);
      end
      bus.up_valid = uv;
      bus.dn_ready = dr;
      #1;
      if (c == 0) begin
        snap  = bus.sel;
        r.err = int'(bus.err);
      end else begin
        for (int i = 0; i < int'(N); i++) if (bus.sel[i] !== snap[i]) r.sel_moved++;
      end
      if (bus.dn_valid === 1'b1 && r.first_dn < 0) r.first_dn = c;
      if (bus.dn_valid === 1'b1 && dr) r.beats++;
      if (bus.done === 1'b1) begin
        r.done_cnt++;
        if (r.done_c < 0) r.done_c = c;
      end
      if (bus.dn_valid !== (running & uv) || bus.up_ready !== (running & dr)) r.hs_bad++;
      if (running && uv && dr) begin
        left--;
        if (left == 0) r.m_done_c = c + 1;
      end
      @(posedge clk);
      #1;
      if (r.done_c >= 0 && c == r.done_c) begin
        r.idle_after = (bus.cmd_ready === 1'b1 && bus.busy === 1'b0 && bus.done === 1'b0);
        break;
      end
    end
    bus.up_valid = 1'b0;
    bus.dn_ready = 1'b0;
  endtask

  task automatic test_reset();
    int d;
    rst_n = 1'b0;
    bus.up_valid = 1'b1;
    bus.dn_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    d = sel_diff(0, 0);
    n_checks++; if (d !== 0) begin n_fail++; $display("FAIL reset_sel: %0d lanes off, want 0", d); end
    n_checks++; if (bus.up_ready !== 1'b0) begin n_fail++; $display("FAIL reset_up_ready: got %b want 0", bus.up_ready); end
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
    n_checks++; if (bus.dn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dn_valid: got %b want 0", bus.dn_valid); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst_n = 1'b1;
    bus.up_valid = 1'b0;
    bus.dn_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_swap();
    res_t r;
    int   d;
    do_cmd(1, 1, 4, 0, r);
    d = sel_diff(1, 1);
    n_checks++; if (r.acc_wait !== 1) begin n_fail++; $display("FAIL swap_accept: %0d edges, want 1", r.acc_wait); end
    n_checks++; if (d !== 0) begin n_fail++; $display("FAIL swap_sel: %0d lanes off, want 0", d); end
    n_checks++; if (bus.sel[5] !== 3'd7) begin n_fail++; $display("FAIL swap_sel5: got %0d want 7", bus.sel[5]); end
    n_checks++; if (r.first_dn !== 1) begin n_fail++; $display("FAIL swap_first_dn: got c=%0d want 1", r.first_dn); end
    n_checks++; if (r.beats !== 4) begin n_fail++; $display("FAIL swap_beats: got %0d want 4", r.beats); end
    n_checks++; if (r.done_c !== 5) begin n_fail++; $display("FAIL swap_done_cycle: got %0d want 5", r.done_c); end
    n_checks++; if (r.done_cnt !== 1) begin n_fail++; $display("FAIL swap_done_count: got %0d want 1", r.done_cnt); end
    n_checks++; if (r.hs_bad !== 0) begin n_fail++; $display("FAIL swap_handshake: %0d bad cycles, want 0", r.hs_bad); end
    n_checks++; if (r.err !== 0) begin n_fail++; $display("FAIL swap_err: got %0d want 0", r.err); end
    n_checks++; if (r.idle_after !== 1) begin n_fail++; $display("FAIL swap_idle_after: got %0d want 1", r.idle_after); end
  endtask

  task automatic test_rotate();
    res_t r;
    int   d;
    do_cmd(2, 3, 3, 1, r);
    d = sel_diff(2, 3);
    n_checks++; if (d !== 0) begin n_fail++; $display("FAIL rot_sel: %0d lanes off, want 0", d); end
    n_checks++; if (r.beats !== 3) begin n_fail++; $display("FAIL rot_beats: got %0d want 3", r.beats); end
    n_checks++; if (r.done_c !== 6) begin n_fail++; $display("FAIL rot_done_cycle: got %0d want 6", r.done_c); end
    n_checks++; if (r.hs_bad !== 0) begin n_fail++; $display("FAIL rot_handshake: %0d bad cycles, want 0", r.hs_bad); end
    n_checks++; if (r.sel_moved !== 0) begin n_fail++; $display("FAIL rot_sel_held: %0d changes, want 0", r.sel_moved); end
  endtask

  task automatic test_bitrev_err();
    res_t r;
    int   d;
    do_cmd(3, 0, 1, 0, r);
    d = sel_diff(3, 0);
    n_checks++; if (d !== 0) begin n_fail++; $display("FAIL brev_sel: %0d lanes off, want 0", d); end
    n_checks++; if (bus.sel[1] !== 3'd4) begin n_fail++; $display("FAIL brev_sel1: got %0d want 4", bus.sel[1]); end
    n_checks++; if (r.done_c !== 2) begin n_fail++; $display("FAIL brev_done_cycle: got %0d want 2", r.done_c); end
    do_cmd(1, 5, 2, 0, r);
    d = sel_diff(0, 0);
    n_checks++; if (r.err !== 1) begin n_fail++; $display("FAIL badk_err: got %0d want 1", r.err); end
    n_checks++; if (d !== 0) begin n_fail++; $display("FAIL badk_sel_identity: %0d lanes off, want 0", d); end
    n_checks++; if (r.beats !== 2) begin n_fail++; $display("FAIL badk_beats: got %0d want 2", r.beats); end
    n_checks++; if (r.done_c !== 3) begin n_fail++; $display("FAIL badk_done_cycle: got %0d want 3", r.done_c); end
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL badk_err_sticky: got %b want 1", bus.err); end
    do_cmd(0, 0, 1, 0, r);
    n_checks++; if (r.err !== 0) begin n_fail++; $display("FAIL err_clear: got %0d want 0", r.err); end
  endtask

  task automatic test_zero_len();
    res_t r;
    do_cmd(2, 2, 0, 0, r);
    n_checks++; if (r.first_dn !== -1) begin n_fail++; $display("FAIL zero_dn_valid: seen at c=%0d want none", r.first_dn); end
    n_checks++; if (r.beats !== 0) begin n_fail++; $display("FAIL zero_beats: got %0d want 0", r.beats); end
    n_checks++; if (r.done_c !== 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 1", r.done_c); end
    n_checks++; if (r.done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", r.done_cnt); end
  endtask

  task automatic test_back_to_back();
    int beats = 0;
    int seen  = 0;
    int d;
    bus.up_valid  = 1'b0;
    bus.dn_ready  = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd0;
    bus.cmd_k     = '0;
    bus.cmd_len   = '0;
    #1;
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready: got %b want 1", bus.cmd_ready); end
    @(posedge clk);
    #1;
    bus.cmd_op  = 2'd3;
    bus.cmd_len = LEN_W'(2);
    #1;
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_load_ready: got %b want 0", bus.cmd_ready); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done_phase: done=%b cmd_ready=%b want 1,0", bus.done, bus.cmd_ready);
    end
    @(posedge clk);
    #1;
    n_checks++; if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: cmd_ready=%b done=%b want 1,0", bus.cmd_ready, bus.done);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    d = sel_diff(3, 0);
    n_checks++; if (bus.busy !== 1'b1 || d !== 0) begin
      n_fail++; $display("FAIL b2b_second_accept: busy=%b sel lanes off=%0d want 1,0", bus.busy, d);
    end
    bus.up_valid = 1'b1;
    bus.dn_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.dn_valid === 1'b1) beats++;
      if (bus.done === 1'b1) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_checks++; if (seen !== 1 || beats !== 2) begin
      n_fail++; $display("FAIL b2b_second_run: done=%0d beats=%0d want 1,2", seen, beats);
    end
    bus.up_valid = 1'b0;
    bus.dn_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    res_t r;
    int   beats = 0;
    int   d;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    bus.cmd_k     = SEL_W'(1);
    bus.cmd_len   = LEN_W'(5);
    bus.up_valid  = 1'b1;
    bus.dn_ready  = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      #1;
      if (bus.dn_valid === 1'b1) beats++;
      @(posedge clk);
      #1;
    end
    n_checks++; if (beats !== 2) begin n_fail++; $display("FAIL mrst_pre_beats: got %0d want 2", beats); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d = sel_diff(0, 0);
    n_checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL mrst_idle: busy=%b cmd_ready=%b want 0,1", bus.busy, bus.cmd_ready);
    end
    n_checks++; if (d !== 0) begin n_fail++; $display("FAIL mrst_sel: %0d lanes off, want 0", d); end
    n_checks++; if (bus.done !== 1'b0 || bus.dn_valid !== 1'b0) begin
      n_fail++; $display("FAIL mrst_outputs: done=%b dn_valid=%b want 0,0", bus.done, bus.dn_valid);
    end
    @(posedge clk);
    #1;
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mrst_no_done: got %b want 0", bus.done); end
    do_cmd(0, 0, 5, 0, r);
    n_checks++; if (r.beats !== 5 || r.done_c !== 6) begin
      n_fail++; $display("FAIL mrst_next_cmd: beats=%0d done_c=%0d want 5,6", r.beats, r.done_c);
    end
  endtask

  task automatic test_random();
    res_t r;
    int   op, k, len, d, exp_err;
    for (int it = 0; it < 12; it++) begin
      op  = int'($urandom_range(3));
      k   = (it % 4 == 3) ? int'($urandom_range(N - 1)) : int'($urandom_range(SEL_W - 1));
      len = int'($urandom_range(12));
      exp_err = (op == 1 && k >= int'(SEL_W)) ? 1 : 0;
      do_cmd(op, k, len, 2, r);
      d = sel_diff(op, k);
      n_checks++; if (d !== 0) begin n_fail++; $display("FAIL rnd%0d_sel: op=%0d k=%0d %0d lanes off", it, op, k, d); end
      n_checks++; if (r.err !== exp_err) begin n_fail++; $display("FAIL rnd%0d_err: got %0d want %0d", it, r.err, exp_err); end
      n_checks++; if (r.beats !== len) begin n_fail++; $display("FAIL rnd%0d_beats: got %0d want %0d", it, r.beats, len); end
      n_checks++; if (r.done_c !== r.m_done_c) begin
        n_fail++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", it, r.done_c, r.m_done_c);
      end
      n_checks++; if (r.done_cnt !== 1) begin n_fail++; $display("FAIL rnd%0d_done_count: got %0d want 1", it, r.done_cnt); end
      n_checks++; if (r.hs_bad !== 0) begin n_fail++; $display("FAIL rnd%0d_handshake: %0d bad cycles", it, r.hs_bad); end
      n_checks++; if (r.sel_moved !== 0) begin n_fail++; $display("FAIL rnd%0d_sel_held: %0d changes", it, r.sel_moved); end
      n_checks++; if (r.idle_after !== 1) begin n_fail++; $display("FAIL rnd%0d_idle_after: got %0d want 1", it, r.idle_after); end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_k     = '0;
    bus.cmd_len   = '0;
    bus.up_valid  = 1'b0;
    bus.dn_ready  = 1'b0;
    test_reset();
    test_swap();
    test_rotate();
    test_bitrev_err();
    test_zero_len();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vmux_sched.md
Name: vmux_sched

Overview:
Sequencer for the lane-permutation multiplexer array in the QFT state-vector datapath. It accepts permutation commands (identity, qubit-bit pair swap, rotate, bit-reverse), computes and holds the N per-lane select codes, then gates a fixed number of amplitude beats through the mux array with valid/ready flow control. It sits between the gate-command decoder and the permutation stage feeding the butterfly units.

Parameters:
N, 8, number of lanes (power of 2, >=2)
SEL_W, $clog2(N), width of one lane select code
LEN_W, 16, width of the beat-count field

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when high with cmd_valid
cmd_op  input  2  0 identity, 1 pair swap, 2 rotate, 3 bit-reverse
cmd_k  input  SEL_W  qubit bit index (op 1) or rotate amount (op 2); ignored for ops 0/3
cmd_len  input  LEN_W  number of beats to pass under this permutation
SEL  output  N x SEL_W (unpacked [N-1:0])  registered lane select codes to the mux array
up_valid  input  1  upstream amplitude vector valid
up_ready  output  1  ready to upstream
dn_valid  output  1  valid to downstream (mux output side)
dn_ready  input  1  downstream ready
busy  output  1  high outside IDLE
done  output  1  one-cycle pulse after last beat
err  output  1  sticky: illegal cmd_k seen; cleared by next accepted command

Behaviour:
- Reset (rst_n low at edge): state IDLE, SEL[i]=i (identity), beat_cnt=0, done=0, err=0, busy=0. Reset mid-command abandons it; no done pulse.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: register SEL from command, load beat_cnt=cmd_len, update err, go LOAD.
- SEL rules, i in 0..N-1, all mod N: op0 SEL[i]=i; op1 SEL[i]=i XOR (1<<cmd_k); op2 SEL[i]=(i+cmd_k) mod N; op3 SEL[i]=bit-reverse of i over SEL_W bits.
- op1 with cmd_k>=SEL_W: SEL=identity, err=1. All other commands set err=0.
- LOAD: one settling cycle, SEL stable, no handshakes (up_ready=0, dn_valid=0). If beat_cnt==0 go DONE, else RUN.
- RUN: combinational pass-through, dn_valid=up_valid, up_ready=dn_ready. Beat fires when up_valid&dn_ready. Each beat decrements beat_cnt; beat at beat_cnt==1 goes DONE. No beat -> hold all state.
- DONE: done=1 for exactly this cycle, up_ready=0, dn_valid=0; next cycle IDLE.
- cmd_ready=0 in LOAD/RUN/DONE; commands wait, none dropped. New command is earliest accepted the cycle after DONE.
- SEL changes only on command acceptance or reset; held constant through LOAD/RUN/DONE and IDLE afterward.
- Command accept to first possible beat: 2 cycles. Throughput in RUN: 1 beat/cycle.
- busy=1 in LOAD, RUN, DONE.

Test Plan:
- Reset: rst_n low 2 cycles with up_valid=1 -> SEL[i]=i, up_ready=0 (cmd_ready=1), dn_valid=0, done=0, err=0, busy=0.
- N=8, op1 k=1 len=4, up_valid/dn_ready always 1 -> SEL={7:5,6:4,5:7,4:6,3:1,2:0,1:3,0:2}, 4 dn_valid cycles starting 2 cycles after accept, done pulse the cycle after the 4th beat.
- op2 k=3 len=3, dn_ready toggling 1,0,1,0,1 -> SEL[i]=(i+3)%8, exactly 3 beats counted only on dn_ready=1, up_ready mirrors dn_ready, done after 3rd beat.
- op3 len=1 -> SEL={0,4,2,6,1,5,3,7} for i=0..7; op1 k=5 len=2 -> SEL identity, err=1, 2 beats, done; next op0 command clears err.
- len=0 command -> LOAD then DONE, no dn_valid, done pulse 2 cycles after accept; back-to-back command held with cmd_valid accepted first cycle in IDLE.
- rst_n low mid-RUN after 2 of 5 beats -> next cycle IDLE, SEL identity, no done pulse, new command runs its full beat count.
